// File: rtl/jtkunio_pkg.sv
// Shared definitions for the Kunio bank-0 ROM arbiter: FSM states, requester ids,
// default ROM offsets inside bank 0 and the round-robin successor helper.
package jtkunio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_WAIT_RDY = 2'd2
  } arb_state_e;

  localparam logic [1:0] MAIN = 2'd0;
  localparam logic [1:0] SND  = 2'd1;
  localparam logic [1:0] PCM  = 2'd2;

  localparam int BA_AW = 22;

  localparam logic [21:0] DEF_SND_OFFSET = 22'h08000;
  localparam logic [21:0] DEF_PCM_OFFSET = 22'h10000;

  // Requester that follows id in the main->snd->pcm ring.
  function automatic logic [1:0] rr_next(input logic [1:0] id);
    logic [1:0] n;
    case (id)
      MAIN:    n = SND;
      SND:     n = PCM;
      default: n = MAIN;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/jtkunio_bank0_arb_if.sv
// Bank-0 read port between the arbiter (master) and the SDRAM controller (slave).
interface jtkunio_bank0_arb_if;
  import jtkunio_pkg::*;

  logic [BA_AW-1:0] ba0_addr;
  logic             ba0_rd;
  logic             ba0_ack;
  logic             ba0_rdy;
  logic [15:0]      data_read;

  modport master (
    output ba0_addr, ba0_rd,
    input  ba0_ack, ba0_rdy, data_read
  );

  modport slave (
    input  ba0_addr, ba0_rd,
    output ba0_ack, ba0_rdy, data_read
  );

endinterface

// File: rtl/jtkunio_wcache.sv
// One-word hit cache for a byte-wide ROM requester: holds valid/tag/word,
// computes the bank word address, the hit/miss flags and the byte select.
module jtkunio_wcache
  import jtkunio_pkg::*;
#(
  parameter int               AW     = 16,
  parameter logic [BA_AW-1:0] OFFSET = 22'd0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             downloading,
  input  logic             cs,
  input  logic [AW-1:0]    addr,
  input  logic             fill_we,
  input  logic [BA_AW-1:0] fill_tag,
  input  logic [15:0]      fill_word,
  output logic             ok,
  output logic [7:0]       data,
  output logic [BA_AW-1:0] word_addr,
  output logic             miss
);

  logic             valid_r;
  logic [BA_AW-1:0] tag_r;
  logic [15:0]      word_r;

  // Tag holds the full bank word address, offset included, so it compares directly.
  assign word_addr = {{(BA_AW-AW+1){1'b0}}, addr[AW-1:1]} + OFFSET;
  assign ok        = cs & valid_r & (tag_r == word_addr) & ~downloading;
  assign miss      = cs & ~ok & ~downloading;

  // Byte select from the cached word.
  always_comb begin
    if (addr[0]) begin
      data = word_r[15:8];
    end else begin
      data = word_r[7:0];
    end
  end

  // Cache storage; a download wipes validity and discards any fill landing meanwhile.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      tag_r   <= 22'd0;
      word_r  <= 16'd0;
    end else begin
      if (downloading) begin
        valid_r <= 1'b0;
      end else if (fill_we) begin
        valid_r <= 1'b1;
      end else begin
        valid_r <= valid_r;
      end
      if (fill_we) begin
        tag_r  <= fill_tag;
        word_r <= fill_word;
      end
    end
  end

endmodule

// File: rtl/jtkunio_bank0_arb.sv
// Bank-0 sharing between main CPU, sound CPU and PCM: per-requester word caches,
// misses serialised onto the single bank read port with round-robin arbitration.
module jtkunio_bank0_arb
  import jtkunio_pkg::*;
#(
  parameter logic [BA_AW-1:0] SND_OFFSET = DEF_SND_OFFSET,
  parameter logic [BA_AW-1:0] PCM_OFFSET = DEF_PCM_OFFSET
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        downloading,
  input  logic        main_cs,
  input  logic [15:0] main_addr,
  output logic [7:0]  main_data,
  output logic        main_ok,
  input  logic        snd_cs,
  input  logic [14:0] snd_addr,
  output logic [7:0]  snd_data,
  output logic        snd_ok,
  input  logic        pcm_cs,
  input  logic [16:0] pcm_addr,
  output logic [7:0]  pcm_data,
  output logic        pcm_ok,
  jtkunio_bank0_arb_if.master ba0
);

  arb_state_e       state_r, nxt_s;
  logic [1:0]       id_r, ptr_r;
  logic [BA_AW-1:0] addr_r;
  logic             rd_r;

  logic [3:0]       miss_s;
  logic [2:0]       fill_we_s;
  logic [BA_AW-1:0] main_wa_s, snd_wa_s, pcm_wa_s, win_addr_s;
  logic [1:0]       c1_s, c2_s, win_s;
  logic             main_miss_s, snd_miss_s, pcm_miss_s;

  jtkunio_wcache #(.AW(16), .OFFSET(22'd0)) u_main (
    .clk(clk), .rst_n(rst_n), .downloading(downloading),
    .cs(main_cs), .addr(main_addr),
    .fill_we(fill_we_s[0]), .fill_tag(addr_r), .fill_word(ba0.data_read),
    .ok(main_ok), .data(main_data), .word_addr(main_wa_s), .miss(main_miss_s)
  );

  jtkunio_wcache #(.AW(15), .OFFSET(SND_OFFSET)) u_snd (
    .clk(clk), .rst_n(rst_n), .downloading(downloading),
    .cs(snd_cs), .addr(snd_addr),
    .fill_we(fill_we_s[1]), .fill_tag(addr_r), .fill_word(ba0.data_read),
    .ok(snd_ok), .data(snd_data), .word_addr(snd_wa_s), .miss(snd_miss_s)
  );

  jtkunio_wcache #(.AW(17), .OFFSET(PCM_OFFSET)) u_pcm (
    .clk(clk), .rst_n(rst_n), .downloading(downloading),
    .cs(pcm_cs), .addr(pcm_addr),
    .fill_we(fill_we_s[2]), .fill_tag(addr_r), .fill_word(ba0.data_read),
    .ok(pcm_ok), .data(pcm_data), .word_addr(pcm_wa_s), .miss(pcm_miss_s)
  );

  // Spare top bit keeps the 2-bit id index inside the vector.
  assign miss_s = {1'b0, pcm_miss_s, snd_miss_s, main_miss_s};

  assign ba0.ba0_addr = addr_r;
  assign ba0.ba0_rd   = rd_r;

  // Round-robin pick: ptr_r is the highest-priority requester this cycle.
  always_comb begin
    c1_s = rr_next(ptr_r);
    c2_s = rr_next(c1_s);
    if (miss_s[ptr_r]) begin
      win_s = ptr_r;
    end else if (miss_s[c1_s]) begin
      win_s = c1_s;
    end else begin
      win_s = c2_s;
    end
    case (win_s)
      MAIN:    win_addr_s = main_wa_s;
      SND:     win_addr_s = snd_wa_s;
      PCM:     win_addr_s = pcm_wa_s;
      default: win_addr_s = 22'd0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (|miss_s[2:0]) nxt_s = ST_WAIT_ACK;
        else              nxt_s = ST_IDLE;
      end
      ST_WAIT_ACK: begin
        if (ba0.ba0_ack) nxt_s = ST_WAIT_RDY;
        else             nxt_s = ST_WAIT_ACK;
      end
      ST_WAIT_RDY: begin
        if (ba0.ba0_rdy) nxt_s = ST_IDLE;
        else             nxt_s = ST_WAIT_RDY;
      end
      default: nxt_s = ST_IDLE;
    endcase
  end

  // FSM outputs: steer the returning word into the winner's cache.
  always_comb begin
    fill_we_s = 3'b000;
    if ((state_r == ST_WAIT_RDY) && ba0.ba0_rdy) begin
      case (id_r)
        MAIN:    fill_we_s = 3'b001;
        SND:     fill_we_s = 3'b010;
        PCM:     fill_we_s = 3'b100;
        default: fill_we_s = 3'b000;
      endcase
    end else begin
      fill_we_s = 3'b000;
    end
  end

  // Transaction registers: latched winner, bank address, read strobe and rr pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_r   <= MAIN;
      ptr_r  <= MAIN;
      addr_r <= 22'd0;
      rd_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (|miss_s[2:0]) begin
            id_r   <= win_s;
            addr_r <= win_addr_s;
            rd_r   <= 1'b1;
            ptr_r  <= rr_next(win_s);
          end
        end
        ST_WAIT_ACK: begin
          if (ba0.ba0_ack) rd_r <= 1'b0;
        end
        default: begin
          rd_r <= rd_r;
        end
      endcase
    end
  end

endmodule
